// File: rtl/sda_kernel_ctrl_reg_mc.sv
// Kernel control register block: host register window, per-channel go/done 4-phase handshakes, interrupt.
// Optional cycle counter enabled by defining SDA_KERNEL_CTRL_CYCLE_COUNT_EN.
module sda_kernel_ctrl_reg_mc #(
   parameter int ADDR_WIDTH = 12,
   parameter int CHANNELS   = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reg_req,
   output logic                  reg_ack,
   input  logic                  reg_write_en,
   input  logic [ADDR_WIDTH-1:0] reg_addr,
   input  logic [31:0]           reg_wdata,
   input  logic [3:0]            reg_wstrb,
   output logic [31:0]           reg_rdata,
   output logic [CHANNELS-1:0]   go_r,
   input  logic [CHANNELS-1:0]   go_a,
   input  logic [CHANNELS-1:0]   done_r,
   output logic [CHANNELS-1:0]   done_a,
   output logic                  interrupt
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_GO_REQ   = 3'd1;
   localparam logic [2:0] ST_GO_RTZ   = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_DONE_ACK = 3'd4;
   localparam logic [ADDR_WIDTH-3:0] BASE_WORD = (ADDR_WIDTH-2)'(BASE_ADDR / 4);

   logic [2:0]            state     [CHANNELS];
   logic [2:0]            state_nxt [CHANNELS];
   logic                  ap_start, ap_done, ap_idle, auto_restart, gie;
   logic [CHANNELS-1:0]   ier, isr, chan_en, isr_set, isr_nxt;
   logic [ADDR_WIDTH-3:0] word_off;
   logic [2:0]            idx;
   logic                  in_win, svc, wr0, rd_ctrl;
   logic                  wr_ctrl, wr_gie, wr_ier, wr_isr, wr_chan;
   logic                  all_idle, host_launch, complete, launch;
   logic [31:0]           rdata_nxt, cycles_rd;
   logic                  unused_bits;

   // Only byte 0 carries state; the remaining bus bits are intentionally unused.
   assign unused_bits = &{1'b0, reg_addr[1:0], reg_wdata, reg_wstrb[3:1]};

   assign word_off = reg_addr[ADDR_WIDTH-1:2] - BASE_WORD;
   assign in_win   = (reg_addr[ADDR_WIDTH-1:2] >= BASE_WORD) && (word_off[ADDR_WIDTH-3:3] == '0);
   assign idx      = word_off[2:0];
   // A request still held during its ack cycle is not serviced a second time.
   assign svc      = reg_req && in_win && !reg_ack;
   assign wr0      = svc && reg_write_en && reg_wstrb[0];
   assign rd_ctrl  = svc && !reg_write_en && (idx == 3'd0);
   assign wr_ctrl  = wr0 && (idx == 3'd0);
   assign wr_gie   = wr0 && (idx == 3'd1);
   assign wr_ier   = wr0 && (idx == 3'd2);
   assign wr_isr   = wr0 && (idx == 3'd3);
   assign wr_chan  = wr0 && (idx == 3'd4);

   assign host_launch = wr_ctrl && reg_wdata[0] && ap_idle;
   assign complete    = !ap_idle && all_idle;
   assign launch      = host_launch || (complete && auto_restart);

   // Batch-level idle detection from the registered channel states.
   always_comb begin
      all_idle = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (state[i] != ST_IDLE) begin
            all_idle = 1'b0;
         end else begin
            all_idle = all_idle;
         end
      end
   end

   // Per-channel handshake next-state and done-interrupt events.
   always_comb begin
      isr_set = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         state_nxt[i] = state[i];
         case (state[i])
            ST_IDLE:     state_nxt[i] = (launch && chan_en[i]) ? ST_GO_REQ : ST_IDLE;
            ST_GO_REQ:   state_nxt[i] = go_a[i] ? ST_GO_RTZ : ST_GO_REQ;
            ST_GO_RTZ:   state_nxt[i] = go_a[i] ? ST_GO_RTZ : ST_RUN;
            ST_RUN:      state_nxt[i] = done_r[i] ? ST_DONE_ACK : ST_RUN;
            ST_DONE_ACK: begin
               if (!done_r[i]) begin
                  state_nxt[i] = ST_IDLE;
                  isr_set[i]   = ier[i];
               end else begin
                  state_nxt[i] = ST_DONE_ACK;
               end
            end
            default:     state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   // Hardware set wins over a same-cycle host toggle.
   assign isr_nxt = (isr ^ (wr_isr ? reg_wdata[CHANNELS-1:0] : {CHANNELS{1'b0}})) | isr_set;

   // Read mux for the register window.
   always_comb begin
      case (idx)
         3'd0:    rdata_nxt = {24'h0, auto_restart, 4'h0, ap_idle, ap_done, ap_start};
         3'd1:    rdata_nxt = {31'h0, gie};
         3'd2:    rdata_nxt = {{(32-CHANNELS){1'b0}}, ier};
         3'd3:    rdata_nxt = {{(32-CHANNELS){1'b0}}, isr};
         3'd4:    rdata_nxt = {{(32-CHANNELS){1'b0}}, chan_en};
         3'd5:    rdata_nxt = cycles_rd;
         default: rdata_nxt = 32'h0;
      endcase
   end

   // Channel state registers and their registered handshake outputs.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (reset) begin
            state[i]  <= ST_IDLE;
            go_r[i]   <= 1'b0;
            done_a[i] <= 1'b0;
         end else begin
            state[i]  <= state_nxt[i];
            go_r[i]   <= (state_nxt[i] == ST_GO_REQ);
            done_a[i] <= (state_nxt[i] == ST_DONE_ACK);
         end
      end
   end

   // Host-visible control/status registers and bus response.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_ack      <= 1'b0;
         reg_rdata    <= 32'h0;
         ap_start     <= 1'b0;
         ap_done      <= 1'b0;
         ap_idle      <= 1'b1;
         auto_restart <= 1'b0;
         gie          <= 1'b0;
         ier          <= '0;
         isr          <= '0;
         chan_en      <= '1;
         interrupt    <= 1'b0;
      end else begin
         reg_ack   <= svc;
         reg_rdata <= (svc && !reg_write_en) ? rdata_nxt : 32'h0;
         ap_start  <= launch;
         if (complete) begin
            ap_done <= 1'b1;
         end else if (rd_ctrl) begin
            ap_done <= 1'b0;
         end else begin
            ap_done <= ap_done;
         end
         if (host_launch) begin
            ap_idle <= 1'b0;
         end else if (complete) begin
            ap_idle <= !auto_restart;
         end else begin
            ap_idle <= ap_idle;
         end
         if (wr_ctrl) auto_restart <= reg_wdata[7];
         else         auto_restart <= auto_restart;
         if (wr_gie)  gie <= reg_wdata[0];
         else         gie <= gie;
         if (wr_ier)  ier <= reg_wdata[CHANNELS-1:0];
         else         ier <= ier;
         if (wr_chan) chan_en <= reg_wdata[CHANNELS-1:0];
         else         chan_en <= chan_en;
         isr       <= isr_nxt;
         interrupt <= gie && (|isr);
      end
   end

`ifdef SDA_KERNEL_CTRL_CYCLE_COUNT_EN
   logic [31:0] cycles;

   // Busy-cycle counter, restarted at every launch and saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles <= 32'h0;
      end else if (launch) begin
         cycles <= 32'h0;
      end else if (!ap_idle && (cycles != 32'hFFFF_FFFF)) begin
         cycles <= cycles + 32'd1;
      end else begin
         cycles <= cycles;
      end
   end

   assign cycles_rd = cycles;
`else
   assign cycles_rd = 32'h0;
`endif

endmodule
